// File: rtl/mdio_phy_responder_if.sv
// MDIO line, link indication and register-write strobe bundle between a
// management master (MAC side) and the emulated PHY responder.
interface mdio_phy_responder_if;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic        link_up;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        busy;

    modport slave (
        input  mdc, mdio_in, link_up,
        output mdio_out, mdio_oen, reg_wr_en, reg_wr_addr, reg_wr_data, busy
    );

    modport master (
        output mdc, mdio_in, link_up,
        input  mdio_out, mdio_oen, reg_wr_en, reg_wr_addr, reg_wr_data, busy
    );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: oversamples MDC in the sys_clk domain, emulates
// a small PHY register set and strobes every accepted write to fabric logic.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter logic [15:0] CTRL_RESET   = 16'h1140,
    parameter logic [15:0] STATUS_BASE  = 16'h7949,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                  i_sys_clk,
    input  logic                  i_core_reset_n,
    mdio_phy_responder_if.slave   io_mdio
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ST2   = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_RD    = 3'd5;
    localparam logic [2:0] S_WTA   = 3'd6;
    localparam logic [2:0] S_WDATA = 3'd7;

    localparam logic [5:0]      PRE_LEN = 6'(PREAMBLE_LEN);
    localparam logic [5:0]      PRE_MAX = 6'd32;
    localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      r_mdc_s;
    logic [1:0]      r_mdio_s;
    logic [1:0]      r_link_s;
    logic            r_mdc_d;
    logic [2:0]      r_state;
    logic [5:0]      r_pre;
    logic [4:0]      r_cnt;
    logic            r_op0;
    logic            r_is_rd;
    logic [14:0]     r_sh;
    logic [15:0]     r_rdata;
    logic [4:0]      r_regad;
    logic [TO_W-1:0] r_to;
    logic [14:0]     r_reg0;
    logic [15:0]     r_scratch [8];
    logic            r_mdio_out;
    logic            r_mdio_oen;
    logic            r_wr_en;
    logic [4:0]      r_wr_addr;
    logic [15:0]     r_wr_data;

    logic            w_edge;
    logic            w_bit;
    logic [4:0]      w_addr;
    logic [15:0]     w_wdata;
    logic [15:0]     w_rd_data;

    assign w_edge  = r_mdc_s[1] & ~r_mdc_d;
    assign w_bit   = r_mdio_s[1];
    assign w_addr  = {r_sh[3:0], w_bit};
    assign w_wdata = {r_sh, w_bit};

    // Reg 0 bit 15 is self-clearing, so only bits 14:0 are stored.
    always_comb begin
        w_rd_data = '0;
        if (w_addr[4:3] == 2'b10) begin
            w_rd_data = r_scratch[w_addr[2:0]];
        end else begin
            case (w_addr)
                5'd0:    w_rd_data = {1'b0, r_reg0};
                5'd1:    w_rd_data = {STATUS_BASE[15:3], r_link_s[1], STATUS_BASE[1:0]};
                5'd2:    w_rd_data = PHY_ID1;
                5'd3:    w_rd_data = PHY_ID2;
                default: w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_core_reset_n) begin
        if (!i_core_reset_n) begin
            r_mdc_s  <= '0;
            r_mdio_s <= '1;
            r_link_s <= '0;
            r_mdc_d  <= 1'b0;
        end else begin
            r_mdc_s  <= {r_mdc_s[0], io_mdio.mdc};
            r_mdio_s <= {r_mdio_s[0], io_mdio.mdio_in};
            r_link_s <= {r_link_s[0], io_mdio.link_up};
            r_mdc_d  <= r_mdc_s[1];
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_core_reset_n) begin
        if (!i_core_reset_n) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_cnt      <= '0;
            r_op0      <= 1'b0;
            r_is_rd    <= 1'b0;
            r_sh       <= '0;
            r_rdata    <= '0;
            r_regad    <= '0;
            r_to       <= '0;
            r_reg0     <= CTRL_RESET[14:0];
            for (int unsigned i = 0; i < 8; i++) r_scratch[i] <= '0;
            r_mdio_out <= 1'b1;
            r_mdio_oen <= 1'b1;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state != S_IDLE && !w_edge) begin
                if (r_to == TO_LAST) begin
                    r_to       <= '0;
                    r_state    <= S_IDLE;
                    r_mdio_oen <= 1'b1;
                    r_mdio_out <= 1'b1;
                end else begin
                    r_to <= r_to + TO_W'(1);
                end
            end else begin
                r_to <= '0;
                if (w_edge) begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_bit) begin
                                if (r_pre != PRE_MAX) r_pre <= r_pre + 6'd1;
                            end else begin
                                // Clearing here also leaves the count at 0 for the next return to IDLE.
                                r_pre <= '0;
                                if (r_pre >= PRE_LEN) r_state <= S_ST2;
                            end
                        end
                        S_ST2: begin
                            r_cnt   <= '0;
                            r_state <= w_bit ? S_OP : S_IDLE;
                        end
                        S_OP: begin
                            if (r_cnt == 5'd0) begin
                                r_op0 <= w_bit;
                                r_cnt <= 5'd1;
                            end else begin
                                r_cnt   <= '0;
                                r_is_rd <= r_op0;
                                r_state <= (r_op0 != w_bit) ? S_PHYAD : S_IDLE;
                            end
                        end
                        S_PHYAD: begin
                            r_sh <= w_wdata[14:0];
                            if (r_cnt == 5'd4) begin
                                r_cnt   <= '0;
                                r_state <= (w_addr == PHY_ADDR) ? S_REGAD : S_IDLE;
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                        S_REGAD: begin
                            r_sh <= w_wdata[14:0];
                            if (r_cnt == 5'd4) begin
                                r_cnt   <= '0;
                                r_regad <= w_addr;
                                r_rdata <= w_rd_data;
                                r_state <= r_is_rd ? S_RD : S_WTA;
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                        S_RD: begin
                            if (r_cnt == 5'd0) begin
                                r_mdio_oen <= 1'b0;
                                r_mdio_out <= 1'b0;
                                r_cnt      <= 5'd1;
                            end else if (r_cnt <= 5'd16) begin
                                r_mdio_out <= r_rdata[15];
                                r_rdata    <= {r_rdata[14:0], 1'b0};
                                r_cnt      <= r_cnt + 5'd1;
                            end else begin
                                r_mdio_oen <= 1'b1;
                                r_mdio_out <= 1'b1;
                                r_state    <= S_IDLE;
                            end
                        end
                        S_WTA: begin
                            if (r_cnt == 5'd0) begin
                                if (w_bit) r_cnt <= 5'd1;
                                else       r_state <= S_IDLE;
                            end else begin
                                r_cnt   <= '0;
                                r_state <= w_bit ? S_IDLE : S_WDATA;
                            end
                        end
                        S_WDATA: begin
                            r_sh <= w_wdata[14:0];
                            if (r_cnt == 5'd15) begin
                                r_state   <= S_IDLE;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_regad;
                                r_wr_data <= w_wdata;
                                if (r_regad == 5'd0) begin
                                    if (w_wdata[15]) begin
                                        r_reg0 <= CTRL_RESET[14:0];
                                        for (int unsigned i = 0; i < 8; i++) r_scratch[i] <= '0;
                                    end else begin
                                        r_reg0 <= w_wdata[14:0];
                                    end
                                end else if (r_regad[4:3] == 2'b10) begin
                                    r_scratch[r_regad[2:0]] <= w_wdata;
                                end
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign io_mdio.mdio_out    = r_mdio_out;
    assign io_mdio.mdio_oen    = r_mdio_oen;
    assign io_mdio.reg_wr_en   = r_wr_en;
    assign io_mdio.reg_wr_addr = r_wr_addr;
    assign io_mdio.reg_wr_data = r_wr_data;
    assign io_mdio.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: the bench plays the MAC's MDIO master
// at 2.5 MHz MDC against a 50 MHz sys_clk, with a pull-up on the shared line.
module tb_mdio_phy_responder;
    localparam int HALF = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic m_oe;
    logic m_out;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int oen_low  = 0;
    int contend  = 0;

    always #10 clk = ~clk;

    mdio_phy_responder_if bus ();

    assign bus.mdio_in = m_oe ? m_out : (bus.mdio_oen ? 1'b1 : bus.mdio_out);

    mdio_phy_responder #(
        .PHY_ADDR    (5'd1),
        .PREAMBLE_LEN(32),
        .CTRL_RESET  (16'h1140),
        .STATUS_BASE (16'h7949),
        .PHY_ID1     (16'h0141),
        .PHY_ID2     (16'h0CC2),
        .TIMEOUT     (1024)
    ) dut (
        .i_sys_clk     (clk),
        .i_core_reset_n(rst_n),
        .io_mdio       (bus)
    );

    always @(negedge clk) begin
        if (bus.reg_wr_en === 1'b1) wr_cnt++;
        if (bus.mdio_oen === 1'b0) oen_low++;
        if (m_oe && bus.mdio_oen === 1'b0) contend++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tx_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            m_oe  = 1'b1;
            m_out = v[i];
            #HALF bus.mdc = 1'b1;
            #HALF bus.mdc = 1'b0;
        end
        m_oe = 1'b0;
    endtask

    task automatic rx_bits(input int n, output logic [31:0] v);
        v    = '0;
        m_oe = 1'b0;
        for (int i = 0; i < n; i++) begin
            #HALF bus.mdc = 1'b1;
            v = {v[30:0], bus.mdio_in};
            #HALF bus.mdc = 1'b0;
        end
    endtask

    task automatic header(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
        tx_bits(32'hFFFF_FFFF, pre);
        tx_bits({18'd0, 2'b01, op, phy, ra}, 14);
    endtask

    task automatic do_read(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                           output logic ta2, output logic [15:0] d);
        logic [31:0] v;
        header(pre, 2'b10, phy, ra);
        rx_bits(18, v);
        ta2 = v[16];
        d   = v[15:0];
    endtask

    task automatic do_write(input logic [4:0] ra, input logic [15:0] d);
        header(32, 2'b01, 5'd1, ra);
        tx_bits({14'd0, 2'b10, d}, 18);
    endtask

    task automatic read_check(input string tag, input logic [4:0] ra, input logic [15:0] exp);
        logic        ta2;
        logic [15:0] d;
        do_read(32, 5'd1, ra, ta2, d);
        check(tag, d, exp);
    endtask

    task automatic sync_neg(input int n);
        repeat (n) @(posedge clk);
        #10;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ta2;
        logic [15:0] d;
        logic [31:0] v;
        int          w0;
        int          o0;

        rst_n       = 1'b0;
        bus.mdc     = 1'b0;
        bus.link_up = 1'b0;
        m_oe        = 1'b0;
        m_out       = 1'b1;
        sync_neg(3);
        check("rst_oen",   bus.mdio_oen,    1'b1);
        check("rst_out",   bus.mdio_out,    1'b1);
        check("rst_wr_en", bus.reg_wr_en,   1'b0);
        check("rst_waddr", bus.reg_wr_addr, 5'd0);
        check("rst_wdata", bus.reg_wr_data, 16'h0000);
        check("rst_busy",  bus.busy,        1'b0);
        rst_n = 1'b1;
        sync_neg(3);

        do_read(32, 5'd1, 5'd2, ta2, d);
        check("id1_ta2",  ta2, 1'b0);
        check("id1_data", d, 16'h0141);
        check("id1_oen",  bus.mdio_oen, 1'b1);
        check("id1_busy", bus.busy, 1'b0);
        read_check("rst_reg0", 5'd0, 16'h1140);

        w0 = wr_cnt;
        do_write(5'd17, 16'hA5A5);
        check("w17_pulse", wr_cnt - w0, 1);
        check("w17_addr",  bus.reg_wr_addr, 5'd17);
        check("w17_data",  bus.reg_wr_data, 16'hA5A5);
        check("w17_busy",  bus.busy, 1'b0);
        read_check("r17", 5'd17, 16'hA5A5);

        w0 = wr_cnt;
        o0 = oen_low;
        tx_bits(32'hFFFF_FFFF, 32);
        tx_bits({23'd0, 2'b01, 2'b10, 5'd2}, 9);
        check("phy2_busy", bus.busy, 1'b0);
        tx_bits({27'd0, 5'd2}, 5);
        rx_bits(18, v);
        check("phy2_line", v[15:0], 16'hFFFF);
        check("phy2_oen",  oen_low - o0, 0);
        check("phy2_wr",   wr_cnt - w0, 0);

        tx_bits(32'hFFFF_FFFF, 32);
        tx_bits(32'b011, 3);
        check("op11_busy_mid", bus.busy, 1'b1);
        tx_bits(32'b1, 1);
        check("op11_busy", bus.busy, 1'b0);
        check("op11_oen",  oen_low - o0, 0);
        check("op11_wr",   wr_cnt - w0, 0);

        do_read(31, 5'd1, 5'd2, ta2, d);
        check("pre31_line", d, 16'hFFFF);
        check("pre31_oen",  oen_low - o0, 0);
        check("pre31_busy", bus.busy, 1'b0);
        do_read(32, 5'd1, 5'd2, ta2, d);
        check("pre32_ta2",  ta2, 1'b0);
        check("pre32_data", d, 16'h0141);

        do_write(5'd16, 16'h1234);
        read_check("r16", 5'd16, 16'h1234);
        do_write(5'd0, 16'h2100);
        read_check("r0_2100", 5'd0, 16'h2100);
        w0 = wr_cnt;
        do_write(5'd0, 16'h8000);
        check("w0rst_pulse", wr_cnt - w0, 1);
        check("w0rst_addr",  bus.reg_wr_addr, 5'd0);
        check("w0rst_data",  bus.reg_wr_data, 16'h8000);
        read_check("r0_after_rst",  5'd0,  16'h1140);
        read_check("r16_after_rst", 5'd16, 16'h0000);
        read_check("r17_after_rst", 5'd17, 16'h0000);

        bus.link_up = 1'b1;
        read_check("r1_link1", 5'd1, 16'h794D);
        bus.link_up = 1'b0;
        read_check("r1_link0", 5'd1, 16'h7949);

        w0 = wr_cnt;
        do_write(5'd2, 16'hFFFF);
        check("w2_pulse", wr_cnt - w0, 1);
        read_check("r2_ro", 5'd2, 16'h0141);
        do_write(5'd5, 16'h1111);
        read_check("r5_unmapped", 5'd5, 16'h0000);
        read_check("r3", 5'd3, 16'h0CC2);

        w0 = wr_cnt;
        header(32, 2'b10, 5'd1, 5'd2);
        rx_bits(10, v);
        check("to_ta2",   v[8], 1'b0);
        check("to_bits",  v[7:0], 8'h01);
        check("to_drive", bus.mdio_oen, 1'b0);
        sync_neg(1000);
        check("to_busy_pre", bus.busy, 1'b1);
        sync_neg(40);
        check("to_busy", bus.busy, 1'b0);
        check("to_oen",  bus.mdio_oen, 1'b1);
        check("to_out",  bus.mdio_out, 1'b1);
        check("to_wr",   wr_cnt - w0, 0);

        do_write(5'd18, 16'h5555);
        w0 = wr_cnt;
        header(32, 2'b01, 5'd1, 5'd19);
        tx_bits({22'd0, 2'b10, 8'hAB}, 10);
        check("wrst_busy_mid", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("wrst_busy", bus.busy, 1'b0);
        check("wrst_oen",  bus.mdio_oen, 1'b1);
        sync_neg(2);
        rst_n = 1'b1;
        sync_neg(3);
        check("wrst_wr", wr_cnt - w0, 0);

        header(32, 2'b10, 5'd1, 5'd2);
        rx_bits(6, v);
        check("rrst_drive", bus.mdio_oen, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rrst_oen", bus.mdio_oen, 1'b1);
        check("rrst_out", bus.mdio_out, 1'b1);
        sync_neg(2);
        rst_n = 1'b1;
        sync_neg(3);

        read_check("r18_after_reset", 5'd18, 16'h0000);
        w0 = wr_cnt;
        do_write(5'd20, 16'hBEEF);
        check("w20_pulse", wr_cnt - w0, 1);
        check("w20_addr",  bus.reg_wr_addr, 5'd20);
        read_check("r20", 5'd20, 16'hBEEF);
        read_check("r2_final", 5'd2, 16'h0141);

        check("no_contention", contend, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
